// File: rtl/wr_burst_controller.sv
// Burst sequencer for a C3SRAM array: four-phase row waveforms, row wrap-around, optional write-verify.
// Optional feature macro: WR_BURST_CTRL_VERIFY_EN (re-read every written row and flag mismatches).
module wr_burst_controller #(
  parameter int numRows     = 8,
  parameter int numCols     = 8,
  parameter int maxBurst    = 8,
  parameter int phaseCycles = 1,
  localparam int addrW = (numRows > 1) ? $clog2(numRows) : 1,
  localparam int lenW  = (maxBurst > 1) ? $clog2(maxBurst) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic [addrW-1:0]   req_addr_i,
  input  logic [lenW-1:0]    req_len_i,
  input  logic [numCols-1:0] wr_data_i,
  input  logic               wr_data_valid_i,
  output logic               wr_data_ready_o,
  input  logic [numCols-1:0] c3sram_rd_data_i,
  output logic [numCols-1:0] rd_data_o,
  output logic               rd_valid_o,
  output logic               done_o,
  output logic               verify_err_o,
  output logic [numCols-1:0] wr_data_q,
  output logic [numCols-1:0] c3sram_csel_o,
  output logic               c3sram_saen_o,
  output logic               c3sram_w2b_o,
  output logic               c3sram_nprecharge_o,
  output logic [numRows-1:0] c3sram_wl_o
);

  localparam int cycW = (phaseCycles > 1) ? $clog2(phaseCycles) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRITE, S_READ, S_VERIFY} state_t;

  state_t              state, state_next;
  logic [1:0]          phase;
  logic [cycW-1:0]     cyc;
  logic [addrW-1:0]    row;
  logic [lenW-1:0]     remaining;
  logic [numRows-1:0]  row_hot;
  logic                in_op, phase_end, op_end, last_row, row_done, wl_on;

  assign in_op     = (state == S_WRITE) || (state == S_READ) || (state == S_VERIFY);
  assign phase_end = (cyc == cycW'(phaseCycles - 1));
  assign op_end    = in_op && phase_end && (phase == 2'd3);
  assign last_row  = (remaining == '0);
  assign wl_on     = (phase == 2'd1) || (phase == 2'd2);
  assign row_hot   = numRows'(1) << row;

  // With verify enabled a row is only finished once its read-back op completes.
`ifdef WR_BURST_CTRL_VERIFY_EN
  assign row_done = op_end && (state != S_WRITE);
`else
  assign row_done = op_end;
`endif

  assign done_o          = row_done && last_row;
  assign req_ready_o     = (state == S_IDLE);
  assign wr_data_ready_o = (state == S_WDATA);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      phase <= 2'd0;
      cyc   <= '0;
    end else begin
      state <= state_next;
      if (in_op) begin
        if (phase_end) begin
          cyc   <= '0;
          phase <= phase + 2'd1;
        end else begin
          cyc <= cyc + cycW'(1);
        end
      end else begin
        cyc   <= '0;
        phase <= 2'd0;
      end
    end
  end

  always_comb begin
    state_next          = state;
    c3sram_csel_o       = '0;
    c3sram_saen_o       = 1'b0;
    c3sram_w2b_o        = 1'b0;
    c3sram_nprecharge_o = 1'b0;
    c3sram_wl_o         = '0;
    case (state)
      S_IDLE: begin
        if (req_valid_i) state_next = req_write_i ? S_WDATA : S_READ;
      end
      S_WDATA: begin
        if (wr_data_valid_i) state_next = S_WRITE;
      end
      S_WRITE: begin
        c3sram_w2b_o        = 1'b1;
        c3sram_nprecharge_o = 1'b1;
        if (wl_on) c3sram_wl_o = row_hot;
        if (op_end) begin
`ifdef WR_BURST_CTRL_VERIFY_EN
          state_next = S_VERIFY;
`else
          state_next = last_row ? S_IDLE : S_WDATA;
`endif
        end
      end
      S_READ, S_VERIFY: begin
        c3sram_saen_o       = (phase == 2'd2);
        c3sram_csel_o       = phase[0] ? '0 : '1;
        c3sram_nprecharge_o = (phase != 2'd3);
        if (wl_on) c3sram_wl_o = row_hot;
        if (op_end) begin
          if (last_row)               state_next = S_IDLE;
          else if (state == S_READ)   state_next = S_READ;
          else                        state_next = S_WDATA;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Burst bookkeeping, write data latch and read capture at the end of P2.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row        <= '0;
      remaining  <= '0;
      wr_data_q  <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      if ((state == S_IDLE) && req_valid_i) begin
        row       <= req_addr_i;
        remaining <= req_len_i;
      end else if (row_done) begin
        row       <= (row == addrW'(numRows - 1)) ? '0 : row + addrW'(1);
        remaining <= remaining - lenW'(1);
      end
      if ((state == S_WDATA) && wr_data_valid_i) wr_data_q <= wr_data_i;
      if ((state == S_READ) && (phase == 2'd2) && phase_end) begin
        rd_data_o  <= c3sram_rd_data_i;
        rd_valid_o <= 1'b1;
      end
    end
  end

`ifdef WR_BURST_CTRL_VERIFY_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      verify_err_o <= 1'b0;
    end else if ((state == S_VERIFY) && (phase == 2'd2) && phase_end &&
                 (c3sram_rd_data_i != wr_data_q)) begin
      verify_err_o <= 1'b1;
    end
  end
`else
  assign verify_err_o = 1'b0;
`endif

endmodule

// File: doc/wr_burst_controller.md
WR_BURST_CONTROLLER -- requirements
Module: wr_burst_controller

Interface
REQ-001 SHALL have parameter numRows, default 8, meaning number of array rows (wordlines); any value >= 2.
REQ-002 SHALL have parameter numCols, default 8, meaning number of array columns (data width).
REQ-003 SHALL have parameter maxBurst, default 8, meaning maximum rows per request; lenW = $clog2(maxBurst).
REQ-004 SHALL have parameter phaseCycles, default 1, meaning clock cycles each waveform phase is held (>= 1).
REQ-005 SHALL have port clk, input, 1 bit, meaning single clock, rising edge.
REQ-006 SHALL have port nrst, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid_i / req_ready_o, in/out, 1 bit each, meaning request handshake.
REQ-008 SHALL have port req_write_i, input, 1 bit, meaning 1 = write burst, 0 = read burst.
REQ-009 SHALL have port req_addr_i, input, $clog2(numRows) bits, meaning start row.
REQ-010 SHALL have port req_len_i, input, lenW bits, meaning burst length minus one.
REQ-011 SHALL have port wr_data_i, wr_data_valid_i / wr_data_ready_o, in/in/out, numCols/1/1 bits, meaning per-row write data stream.
REQ-012 SHALL have port c3sram_rd_data_i, input, numCols bits, meaning sense-amp outputs.
REQ-013 SHALL have port rd_data_o, rd_valid_o, output, numCols/1 bits, meaning captured read row plus 1-cycle strobe (no backpressure).
REQ-014 SHALL have port done_o, output, 1 bit, meaning 1-cycle pulse at burst end.
REQ-015 SHALL have port verify_err_o, output, 1 bit, meaning sticky write-verify mismatch.
REQ-016 SHALL have port wr_data_q, c3sram_csel_o, c3sram_saen_o, c3sram_w2b_o, c3sram_nprecharge_o, c3sram_wl_o, output, numCols/numCols/1/1/1/numRows bits, meaning array drive signals.

Function
REQ-017 SHALL implement states S_IDLE, S_WDATA, S_WRITE, S_READ, S_VERIFY; req_ready_o = (state == S_IDLE).
REQ-018 SHALL, on req accept in S_IDLE, latch addr, len and direction, then go to S_WDATA (write) or S_READ (read).
REQ-019 SHALL, in S_WDATA, assert wr_data_ready_o, hold every array signal at 0, and on wr_data_valid_i capture wr_data_q and enter S_WRITE next cycle.
REQ-020 SHALL sequence each row op as 4 phases P0..P3, each phaseCycles long, so one row op takes 4*phaseCycles cycles.
REQ-021 SHALL drive writes as P0..P3: w2b 1,1,1,1; nprecharge 1,1,1,1; wl[row] 0,1,1,0; csel and saen 0.
REQ-022 SHALL drive reads as P0..P3: saen 0,0,1,0; csel (all bits) 1,0,1,0; nprecharge 1,1,1,0; wl[row] 0,1,1,0; w2b 0.
REQ-023 SHALL hold all non-target wordlines at 0 in every state, with at most one wl bit high at any time.
REQ-024 SHALL capture c3sram_rd_data_i into rd_data_o on the last cycle of read P2, pulsing rd_valid_o the following cycle.
REQ-025 SHALL, after each row, increment the row address and wrap numRows-1 -> 0 (non-power-of-two safe).
REQ-026 SHALL, after a write row, return to S_WDATA if rows remain; after a read row, restart S_READ if rows remain.
REQ-027 SHALL pulse done_o for one cycle in the last cycle of the final row op and return to S_IDLE on the next cycle.
REQ-028 SHALL, with req_len_i = 0, perform exactly one row op.
REQ-029 SHALL leave the write burst stalled indefinitely in S_WDATA while wr_data_valid_i is low.
REQ-030 SHALL not accept a request while busy, and SHALL ignore wr_data_valid_i outside S_WDATA.

Reset
REQ-031 SHALL asynchronously set on nrst low: state S_IDLE, all array outputs 0, wr_data_q 0, rd_data_o 0, rd_valid_o 0, done_o 0, verify_err_o 0, req_ready_o 1.
REQ-032 SHALL, on reset mid-burst, abandon the burst without a done_o pulse and drop wordlines immediately.

Configuration
REQ-033 SHALL compile in write-verify when WR_BURST_CTRL_VERIFY_EN is defined: after each write row, enter S_VERIFY, run one read op (REQ-022) on the same row, and compare with wr_data_q; mismatch sets verify_err_o until reset.
REQ-034 SHALL, with WR_BURST_CTRL_VERIFY_EN undefined, never enter S_VERIFY, tie verify_err_o to 0, and omit the comparator.
REQ-035 SHALL not assert rd_valid_o during S_VERIFY reads.

Verification
REQ-036 SHALL cover single write: addr=3, len=0, data=0xA5, phaseCycles=1 -> wl[3] high exactly cycles 2-3 of op, w2b high 4 cycles, done_o once.
REQ-037 SHALL cover read burst with wrap: numRows=8, addr=6, len=3 -> wl rows 6,7,0,1 in order, 4 rd_valid_o pulses, data matching model.
REQ-038 SHALL cover write data stall: wr_data_valid_i low 5 cycles -> all array signals 0 for 5 cycles, no done_o.
REQ-039 SHALL cover phaseCycles=3: one read row -> 12 cycles, saen high exactly cycles 7-9.
REQ-040 SHALL cover reset mid-burst: nrst low during P1 of a write -> wl 0 immediately, no done_o, req_ready_o 1 after release.
REQ-041 SHALL cover the VERIFY_EN build: write 0x3C with array returning 0x3D -> verify_err_o set and held until reset.
